// File: rtl/display_pkg.sv
// Shared definitions for the 7-segment scan controller: digit geometry,
// default slot timing and the scan FSM encoding.
package display_pkg;

  localparam int unsigned MAX_DIGITS       = 8;
  localparam int unsigned NIBBLE_W         = 4;
  localparam int unsigned IDX_W            = $clog2(MAX_DIGITS);
  localparam int unsigned DEF_DIV_CYCLES   = 100000;
  localparam int unsigned DEF_BLANK_CYCLES = 1000;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  // Active-low anode pattern: only the selected digit is driven, and only if lit.
  function automatic logic [MAX_DIGITS-1:0] anode_pattern(input logic lit,
                                                          input logic [IDX_W-1:0] idx);
    logic [MAX_DIGITS-1:0] mask;
    mask = '1;
    if (lit) mask[idx] = 1'b0;
    return mask;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_scan_timer.sv
// Slot timer: free-running counter 0..DIV_CYCLES-1 with strobes marking the
// last cycle of a slot and the last cycle of the blanking window.
module scan_timer
  import display_pkg::*;
#(
  parameter int unsigned DIV_CYCLES   = DEF_DIV_CYCLES,
  parameter int unsigned BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_slot_wrap,
  output logic o_blank_done
);

  localparam int unsigned CNT_W = $clog2(DIV_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap       = (r_cnt == CNT_W'(DIV_CYCLES - 1));
  assign o_slot_wrap  = w_wrap;
  assign o_blank_done = (r_cnt == CNT_W'(BLANK_CYCLES - 1));

  // Slot counter, wraps to zero after DIV_CYCLES-1.
  always_ff @(posedge i_clk) begin
    if (i_reset)     r_cnt <= '0;
    else if (w_wrap) r_cnt <= '0;
    else             r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit common-anode 7-segment
// display. Double-buffered display data is committed only at frame wrap.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned N_DIGITS     = MAX_DIGITS,
  parameter int unsigned DIV_CYCLES   = DEF_DIV_CYCLES,
  parameter int unsigned BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [MAX_DIGITS*NIBBLE_W-1:0]   data_in,
  input  logic [MAX_DIGITS-1:0]            dp_in,
  input  logic [MAX_DIGITS-1:0]            en_in,
  input  logic                             load,
  output logic                             load_pending,
  output logic [NIBBLE_W-1:0]              nibble,
  output logic [MAX_DIGITS-1:0]            an,
  output logic                             dp,
  output logic [IDX_W-1:0]                 digit_idx,
  output logic                             frame_tick
);

  if (N_DIGITS < 1 || N_DIGITS > MAX_DIGITS || DIV_CYCLES < 2 ||
      BLANK_CYCLES < 1 || BLANK_CYCLES >= DIV_CYCLES) begin : g_param_check
    $error("display_scan_ctrl: illegal N_DIGITS/DIV_CYCLES/BLANK_CYCLES");
  end

  localparam int unsigned DATA_W = MAX_DIGITS * NIBBLE_W;

  logic                  w_slot_wrap;
  logic                  w_blank_done;
  logic                  w_last_digit;
  logic                  w_frame_wrap;
  logic [IDX_W-1:0]      w_next_idx;
  logic [DATA_W-1:0]     w_act_data_nxt;
  logic [MAX_DIGITS-1:0] w_act_dp_nxt;
  logic [MAX_DIGITS-1:0] w_act_en_nxt;
  logic [MAX_DIGITS-1:0] w_an_show;
  logic                  w_dp_show;

  logic [DATA_W-1:0]     r_sh_data;
  logic [MAX_DIGITS-1:0] r_sh_dp;
  logic [MAX_DIGITS-1:0] r_sh_en;
  logic [DATA_W-1:0]     r_act_data;
  logic [MAX_DIGITS-1:0] r_act_dp;
  logic [MAX_DIGITS-1:0] r_act_en;
  logic                  r_pending;

  scan_state_e           r_state;
  logic [MAX_DIGITS-1:0] r_an;
  logic                  r_dp;
  logic [NIBBLE_W-1:0]   r_nibble;
  logic [IDX_W-1:0]      r_digit_idx;
  logic                  r_frame_tick;

  scan_timer #(
    .DIV_CYCLES   (DIV_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_scan_timer (
    .i_clk        (clk),
    .i_reset      (reset),
    .o_slot_wrap  (w_slot_wrap),
    .o_blank_done (w_blank_done)
  );

  assign w_last_digit = (r_digit_idx == IDX_W'(N_DIGITS - 1));
  assign w_frame_wrap = w_slot_wrap && w_last_digit;
  assign w_next_idx   = !w_slot_wrap ? r_digit_idx :
                        (w_last_digit ? '0 : r_digit_idx + 1'b1);

  // Active buffer as it will be after this edge. A load sampled on the
  // frame-wrap edge bypasses the shadow so it is visible on digit 0 at once.
  always_comb begin
    w_act_data_nxt = r_act_data;
    w_act_dp_nxt   = r_act_dp;
    w_act_en_nxt   = r_act_en;
    if (w_frame_wrap) begin
      if (load) begin
        w_act_data_nxt = data_in;
        w_act_dp_nxt   = dp_in;
        w_act_en_nxt   = en_in;
      end else if (r_pending) begin
        w_act_data_nxt = r_sh_data;
        w_act_dp_nxt   = r_sh_dp;
        w_act_en_nxt   = r_sh_en;
      end
    end
  end

  assign w_an_show = anode_pattern(r_act_en[r_digit_idx], r_digit_idx);
  assign w_dp_show = ~(r_act_en[r_digit_idx] & r_act_dp[r_digit_idx]);

  // Shadow/active double buffer and pending flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sh_data  <= '0;
      r_sh_dp    <= '0;
      r_sh_en    <= '0;
      r_act_data <= '0;
      r_act_dp   <= '0;
      r_act_en   <= '0;
      r_pending  <= 1'b0;
    end else begin
      if (load) begin
        r_sh_data <= data_in;
        r_sh_dp   <= dp_in;
        r_sh_en   <= en_in;
      end
      r_act_data <= w_act_data_nxt;
      r_act_dp   <= w_act_dp_nxt;
      r_act_en   <= w_act_en_nxt;
      if (w_frame_wrap) r_pending <= 1'b0;
      else if (load)    r_pending <= 1'b1;
    end
  end

  // Scan FSM with registered anode, decimal point, nibble, index and tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= BLANK;
      r_an         <= '1;
      r_dp         <= 1'b1;
      r_nibble     <= '0;
      r_digit_idx  <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_frame_wrap;
      if (w_slot_wrap) begin
        r_digit_idx <= w_next_idx;
        r_nibble    <= w_act_data_nxt[{w_next_idx, 2'b00} +: NIBBLE_W];
      end
      case (r_state)
        BLANK: begin
          if (w_blank_done) begin
            r_state <= SHOW;
            r_an    <= w_an_show;
            r_dp    <= w_dp_show;
          end
        end
        SHOW: begin
          if (w_slot_wrap) begin
            r_state <= BLANK;
            r_an    <= '1;
            r_dp    <= 1'b1;
          end
        end
        default: begin
          r_state <= BLANK;
          r_an    <= '1;
          r_dp    <= 1'b1;
        end
      endcase
    end
  end

  assign load_pending = r_pending;
  assign nibble       = r_nibble;
  assign an           = r_an;
  assign dp           = r_dp;
  assign digit_idx    = r_digit_idx;
  assign frame_tick   = r_frame_tick;

endmodule
